i2c_byte_serializer: RTL and testbench
======================================

# i2c_byte_serializer

Upstream feeder for the I2C start/stop/SCL unit. Accepts a write transaction (7-bit address, byte count, data bytes through a stream handshake) and drives `busy` to the start/stop unit. Tracks the SCL it returns and shifts address and data bits onto SDA on SCL falling edges. Samples the slave ACK on SCL rising edges and reports completion or NACK.

## Interface
- `MAX_BYTES`, 4: maximum data bytes per transaction; `LEN_W = $clog2(MAX_BYTES+1)`.
- `mclk`  in  1  system clock, single clock domain.
- `rst`  in  1  reset, asynchronous, active-high.
- `cmd_valid`  in  1  transaction request.
- `cmd_ready`  out  1  high only in IDLE.
- `cmd_addr`  in  7  slave address.
- `cmd_len`  in  LEN_W  data byte count, 0..MAX_BYTES; larger values saturate to MAX_BYTES.
- `wr_valid`  in  1  write byte available.
- `wr_ready`  out  1  one-cycle pulse when a byte is consumed.
- `wr_data`  in  8  write byte.
- `scl_i`  in  1  SCL from start/stop unit.
- `sda_i`  in  1  SDA line readback for ACK.
- `busy`  out  1  to start/stop unit; high for whole transaction.
- `sda_o`  out  1  serial data bit.
- `sda_oe`  out  1  1 = drive `sda_o`, 0 = released (ACK slot).
- `done`  out  1  one-cycle pulse at transaction end.
- `nack`  out  1  registered error flag, valid with `done`, held until next accepted command.

## Operation
- Edge detect: `scl_q` <= `scl_i`. fall = `scl_q & ~scl_i`, rise = `~scl_q & scl_i`.
- States: IDLE, START_WAIT, SHIFT, ACK, END.
- IDLE: `cmd_valid & cmd_ready` latches {addr, R/W=0} into the shift register and saturated len into `remaining`. Clears `nack`, sets `busy`, goes to START_WAIT.
- START_WAIT: first fall → `sda_oe`=1, drive MSB, bit_cnt=7, go to SHIFT.
- SHIFT: each fall shifts the next bit (MSB first). After the 8th bit has been driven, the next fall sets `sda_oe`=0 and goes to ACK.
- ACK: on rise, sample `sda_i`; 1 sets `nack`. On the following fall:
  - If `remaining`=0, go to END.
  - Else if `wr_valid`=1, load `wr_data`, pulse `wr_ready`, decrement `remaining`, drive the MSB, go to SHIFT.
  - Else (underflow), set `nack` and go to END.
- END: `busy`=0, `sda_oe`=0, pulse `done`, go to IDLE. `cmd_ready` returns the next cycle.
- `cmd_len`=0 gives an address-only transaction (9 SCL cycles).
- `wr_valid` is only examined at byte boundaries. `wr_data` is captured in the same cycle as `wr_ready`.

## Timing
- Reset values: `busy`=0, `sda_o`=1, `sda_oe`=0, `wr_ready`=0, `done`=0, `nack`=0, `cmd_ready`=0 while `rst` is high, state=IDLE, `scl_q`=1. `cmd_ready`=1 on the first cycle after release.
- Edge detection adds 1 `mclk` of latency: SDA changes one cycle after the `scl_i` falling transition, still inside the SCL low phase.
- ACK is sampled on the cycle the rise is detected.
- `busy` rises the cycle after the command is accepted. It falls on the cycle after the final ACK-slot fall, alongside the `done` pulse.
- Simultaneous rise and fall cannot occur. Edges arriving in IDLE or END are ignored.
- `rst` mid-transaction: all outputs return to reset values immediately. No `done` pulse; a partial byte is discarded.
- `cmd_valid` while busy is not accepted; the command must be held.

## Configuration
- `I2C_NACK_ABORT_EN` defined: a NACK sampled in any ACK slot goes directly to END at the next fall. Remaining bytes are not requested (no further `wr_ready`) and `nack`=1.
- Not defined: a NACK only sets `nack`; the transaction continues through all `cmd_len` bytes.
- Underflow always ends the transaction, in both builds.

## Structure
- Shared package `i2c_pkg`: state enum, `I2C_ADDR_W`=7, `I2C_BYTE_W`=8, R/W bit encodings (WRITE=0, READ=1). The start/stop unit uses the same package.
- One sub-module `i2c_scl_edge`: registers `scl_i` and outputs `scl_rise` and `scl_fall`. Reusable by the future receive path.

## Test plan
- Addr 0x50, len 1, data 0xA5, `sda_i`=0 in ACK slots:
  - SDA bits 1010000 0, ACK, 10100101, ACK.
  - `wr_ready` pulses once; `done` pulses after 18 SCL cycles; `nack`=0.
- Len 0, addr 0x7F, `sda_i`=1 in ACK:
  - Bits 1111111 0; `done` after 9 SCL cycles; `nack`=1.
- Len 3, `wr_valid` low at the second byte boundary:
  - `wr_ready` pulses once; transaction ends with `nack`=1; `busy` drops.
- With `I2C_NACK_ABORT_EN`, len 2, NACK on the address byte:
  - No `wr_ready`; `busy` low after 9 SCL cycles; `nack`=1.
  - Without the macro, both bytes are sent.
- Assert `rst` at bit 4 of the data byte:
  - `busy`=0, `sda_oe`=0, `sda_o`=1 in the same cycle; no `done`.
  - After release, a new command is accepted immediately.
- `cmd_len`=7 with `MAX_BYTES`=4: exactly 4 `wr_ready` pulses.

Source files
------------

// File: rtl/i2c_pkg.sv
// i2c_pkg: definitions shared by the I2C transmit path (byte serializer and
// start/stop/SCL unit).
//   I2C_ADDR_W / I2C_BYTE_W : field widths on the bus
//   i2c_rw_e                : R/W bit encoding appended to the 7-bit address
//   i2c_state_e             : serializer state encoding
package i2c_pkg;

  localparam int I2C_ADDR_W = 7;
  localparam int I2C_BYTE_W = 8;

  typedef enum logic {
    I2C_WRITE = 1'b0,
    I2C_READ  = 1'b1
  } i2c_rw_e;

  typedef enum logic [2:0] {
    I2C_ST_IDLE       = 3'd0,
    I2C_ST_START_WAIT = 3'd1,
    I2C_ST_SHIFT      = 3'd2,
    I2C_ST_ACK        = 3'd3,
    I2C_ST_END        = 3'd4
  } i2c_state_e;

endpackage

// File: rtl/i2c_scl_edge.sv
// i2c_scl_edge: registers the SCL returned by the start/stop unit and flags
// its transitions.
//   mclk, rst   : system clock, asynchronous active-high reset
//   scl_i       : SCL level
//   scl_rise    : high for the cycle in which a 0->1 transition is seen
//   scl_fall    : high for the cycle in which a 1->0 transition is seen
// The register resets to 1 (bus idle level) so no edge is reported on the
// first cycle after reset while SCL is high.
module i2c_scl_edge (
  input  logic mclk,
  input  logic rst,
  input  logic scl_i,
  output logic scl_rise,
  output logic scl_fall
);

  logic scl_q;

  always_ff @(posedge mclk or posedge rst) begin
    if (rst) begin
      scl_q <= 1'b1;
    end else begin
      scl_q <= scl_i;
    end
  end

  assign scl_fall = scl_q & ~scl_i;
  assign scl_rise = ~scl_q & scl_i;

endmodule

// File: rtl/i2c_byte_serializer.sv
// i2c_byte_serializer: feeds an I2C write transaction to the start/stop unit.
// Accepts {address, length}, holds busy for the whole transaction, shifts the
// address byte (R/W = write) and the data bytes MSB first onto SDA on SCL
// falling edges, releases SDA in each ACK slot and samples the slave ACK on
// the SCL rising edge.
//   mclk, rst              : system clock, asynchronous active-high reset
//   cmd_valid/ready/addr/len : transaction request (len saturates to MAX_BYTES)
//   wr_valid/ready/data    : data byte stream, wr_ready pulses when consumed
//   scl_i, sda_i           : SCL from start/stop unit, SDA readback
//   busy                   : transaction in progress (to start/stop unit)
//   sda_o, sda_oe          : serial data and its drive enable
//   done, nack             : end-of-transaction pulse, sticky error flag
// Build option: define I2C_NACK_ABORT_EN to end the transaction at the first
// NACKed byte instead of sending the remaining bytes.
module i2c_byte_serializer
  import i2c_pkg::*;
#(
  parameter int MAX_BYTES = 4,
  parameter int LEN_W     = $clog2(MAX_BYTES + 1)
) (
  input  logic                  mclk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [I2C_ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]      cmd_len,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [I2C_BYTE_W-1:0] wr_data,
  input  logic                  scl_i,
  input  logic                  sda_i,
  output logic                  busy,
  output logic                  sda_o,
  output logic                  sda_oe,
  output logic                  done,
  output logic                  nack
);

  localparam logic [2:0] S_IDLE       = 3'(I2C_ST_IDLE);
  localparam logic [2:0] S_START_WAIT = 3'(I2C_ST_START_WAIT);
  localparam logic [2:0] S_SHIFT      = 3'(I2C_ST_SHIFT);
  localparam logic [2:0] S_ACK        = 3'(I2C_ST_ACK);
  localparam logic [2:0] S_END        = 3'(I2C_ST_END);

  function automatic logic [LEN_W-1:0] sat_len(input logic [LEN_W-1:0] len);
    if (len > LEN_W'(MAX_BYTES)) begin
      return LEN_W'(MAX_BYTES);
    end
    return len;
  endfunction

  logic [2:0]            state;
  logic [2:0]            bit_cnt;
  logic [LEN_W-1:0]      remaining;
  logic [I2C_BYTE_W-1:0] shreg;
  logic                  scl_rise;
  logic                  scl_fall;
  logic                  addr_load;
  logic                  bit_shift;
  logic                  byte_load;

  i2c_scl_edge u_scl_edge (
    .mclk     (mclk),
    .rst      (rst),
    .scl_i    (scl_i),
    .scl_rise (scl_rise),
    .scl_fall (scl_fall)
  );

  // Gated with rst so the request is refused for the whole reset pulse.
  assign cmd_ready = (state == S_IDLE) & ~rst;

  assign addr_load = (state == S_IDLE) & cmd_valid;
  assign bit_shift = scl_fall & ((state == S_START_WAIT) |
                                 ((state == S_SHIFT) & (bit_cnt != 3'd0)));

  // A byte is taken only on the fall that closes an ACK slot, so wr_valid is
  // ignored everywhere else. wr_data is captured on the clock edge that ends
  // this cycle, which is the cycle wr_ready is high.
  always_comb begin
    byte_load = 1'b0;
    if ((state == S_ACK) && scl_fall && (remaining != '0) && wr_valid) begin
      byte_load = 1'b1;
    end
`ifdef I2C_NACK_ABORT_EN
    // Any earlier NACK would already have ended the transaction, so a set
    // flag here means the slot just closing was NACKed.
    if (nack) begin
      byte_load = 1'b0;
    end
`else
`endif
  end

  assign wr_ready = byte_load;

  // Shift register holds the bits still to be driven, MSB aligned.
  always_ff @(posedge mclk) begin
    if (addr_load) begin
      shreg <= {cmd_addr, I2C_WRITE};
    end else if (byte_load) begin
      shreg <= {wr_data[I2C_BYTE_W-2:0], 1'b0};
    end else if (bit_shift) begin
      shreg <= {shreg[I2C_BYTE_W-2:0], 1'b0};
    end
  end

  always_ff @(posedge mclk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      bit_cnt   <= 3'd0;
      remaining <= '0;
      busy      <= 1'b0;
      sda_o     <= 1'b1;
      sda_oe    <= 1'b0;
      done      <= 1'b0;
      nack      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            remaining <= sat_len(cmd_len);
            nack      <= 1'b0;
            busy      <= 1'b1;
            state     <= S_START_WAIT;
          end
        end
        S_START_WAIT: begin
          if (scl_fall) begin
            sda_oe  <= 1'b1;
            sda_o   <= shreg[I2C_BYTE_W-1];
            bit_cnt <= 3'd7;
            state   <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          // bit_cnt counts bits not yet driven; the fall after the last one
          // opens the ACK slot.
          if (scl_fall) begin
            if (bit_cnt != 3'd0) begin
              sda_o   <= shreg[I2C_BYTE_W-1];
              bit_cnt <= bit_cnt - 3'd1;
            end else begin
              sda_oe <= 1'b0;
              sda_o  <= 1'b1;
              state  <= S_ACK;
            end
          end
        end
        S_ACK: begin
          if (scl_rise && sda_i) begin
            nack <= 1'b1;
          end
          if (scl_fall) begin
            if (byte_load) begin
              sda_oe    <= 1'b1;
              sda_o     <= wr_data[I2C_BYTE_W-1];
              remaining <= remaining - LEN_W'(1);
              bit_cnt   <= 3'd7;
              state     <= S_SHIFT;
            end else begin
              // Bytes still owed but not taken: underflow (or abort, where
              // nack is already set).
              if (remaining != '0) begin
                nack <= 1'b1;
              end
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= S_END;
            end
          end
        end
        S_END: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_byte_serializer.sv
// Directed bench for i2c_byte_serializer: plays the start/stop unit (SCL of
// 8 mclk per bit) and the slave (ACK/NACK per slot), feeds the byte stream,
// and checks the serialized bits, handshakes, completion and reset behaviour
// against hand-computed values.
module tb_i2c_byte_serializer;

  localparam int MAX_BYTES = 4;
  localparam int LEN_W     = 3;

  logic             mclk = 1'b0;
  logic             rst = 1'b1;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [6:0]       cmd_addr = '0;
  logic [LEN_W-1:0] cmd_len = '0;
  logic             wr_valid = 1'b0;
  logic             wr_ready;
  logic [7:0]       wr_data = '0;
  logic             scl_i = 1'b1;
  logic             sda_i = 1'b1;
  logic             busy;
  logic             sda_o;
  logic             sda_oe;
  logic             done;
  logic             nack;

  always #5 mclk = ~mclk;

  i2c_byte_serializer #(.MAX_BYTES(MAX_BYTES)) dut (
    .mclk      (mclk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_addr  (cmd_addr),
    .cmd_len   (cmd_len),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_data   (wr_data),
    .scl_i     (scl_i),
    .sda_i     (sda_i),
    .busy      (busy),
    .sda_o     (sda_o),
    .sda_oe    (sda_oe),
    .done      (done),
    .nack      (nack)
  );

  int errors = 0;
  int checks = 0;
  int wr_cnt = 0;
  int done_cnt = 0;
  int done_at = -1;
  int cur_cyc = 0;

  logic       ack_v [0:7];
  logic       wv    [0:7];
  logic [7:0] wd    [0:7];
  logic [63:0] bit_o;
  logic [63:0] bit_oe;

  always @(negedge mclk) begin
    if (wr_ready) wr_cnt++;
    if (done) begin
      done_cnt++;
      done_at = cur_cyc;
    end
  end

  task automatic wait_mclk(input int n);
    repeat (n) @(posedge mclk);
    #1;
  endtask

  task automatic set_slots(input logic ack, input logic valid, input logic [7:0] d0);
    for (int k = 0; k < 8; k++) begin
      ack_v[k] = ack;
      wv[k]    = valid;
      wd[k]    = d0 + 8'(k);
    end
  endtask

  // SCL low phase of bit cycle i; the ACK slot is every 9th cycle.
  task automatic do_low(input int i);
    cur_cyc = i;
    scl_i   = 1'b0;
    sda_i   = (i % 9 == 8) ? ack_v[i / 9] : 1'b1;
    if (i > 0 && i % 9 == 0) begin
      wr_valid = wv[i / 9 - 1];
      wr_data  = wd[i / 9 - 1];
    end
    wait_mclk(4);
    wr_valid = 1'b0;
  endtask

  task automatic do_high(input int i);
    bit_o[i]  = sda_o;
    bit_oe[i] = sda_oe;
    scl_i     = 1'b1;
    wait_mclk(4);
  endtask

  task automatic run_txn(input int maxcyc);
    int d0;
    d0 = done_cnt;
    bit_o  = '0;
    bit_oe = '0;
    for (int i = 0; i < maxcyc; i++) begin
      do_low(i);
      if (done_cnt != d0) break;
      do_high(i);
    end
    scl_i = 1'b1;
    sda_i = 1'b1;
    wait_mclk(3);
  endtask

  task automatic send_cmd(input logic [6:0] addr, input logic [LEN_W-1:0] len);
    int n;
    n = 0;
    cmd_addr  = addr;
    cmd_len   = len;
    cmd_valid = 1'b1;
    while (!cmd_ready && n < 20) begin
      wait_mclk(1);
      n++;
    end
    wait_mclk(1);
    cmd_valid = 1'b0;
  endtask

  function automatic logic [7:0] byte_at(input int first);
    logic [7:0] b;
    for (int k = 0; k < 8; k++) b[7-k] = bit_o[first + k];
    return b;
  endfunction

  task automatic test_reset();
    wait_mclk(2);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (sda_o !== 1'b1) begin errors++; $display("FAIL reset_sda_o got=%b exp=1", sda_o); end
    checks++; if (sda_oe !== 1'b0) begin errors++; $display("FAIL reset_sda_oe got=%b exp=0", sda_oe); end
    checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL reset_wr_ready got=%b exp=0", wr_ready); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (nack !== 1'b0) begin errors++; $display("FAIL reset_nack got=%b exp=0", nack); end
    checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL reset_cmd_ready_in_rst got=%b exp=0", cmd_ready); end
    rst = 1'b0;
    #1;
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready_after got=%b exp=1", cmd_ready); end
    wait_mclk(1);
  endtask

  task automatic test_one_byte();
    int w0, d0;
    set_slots(1'b0, 1'b1, 8'hA5);
    w0 = wr_cnt; d0 = done_cnt;
    send_cmd(7'h50, 3'd1);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL one_busy_set got=%b exp=1", busy); end
    checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL one_cmd_ready_busy got=%b exp=0", cmd_ready); end
    run_txn(40);
    checks++; if (byte_at(0) !== 8'hA0) begin errors++; $display("FAIL one_addr_bits got=%h exp=a0", byte_at(0)); end
    checks++; if (bit_oe[8:0] !== 9'h0FF) begin errors++; $display("FAIL one_addr_oe got=%h exp=0ff", bit_oe[8:0]); end
    checks++; if (byte_at(9) !== 8'hA5) begin errors++; $display("FAIL one_data_bits got=%h exp=a5", byte_at(9)); end
    checks++; if (bit_oe[17:9] !== 9'h0FF) begin errors++; $display("FAIL one_data_oe got=%h exp=0ff", bit_oe[17:9]); end
    checks++; if (wr_cnt - w0 !== 1) begin errors++; $display("FAIL one_wr_ready got=%0d exp=1", wr_cnt - w0); end
    checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL one_done_count got=%0d exp=1", done_cnt - d0); end
    checks++; if (done_at !== 18) begin errors++; $display("FAIL one_done_cycle got=%0d exp=18", done_at); end
    checks++; if (nack !== 1'b0) begin errors++; $display("FAIL one_nack got=%b exp=0", nack); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL one_busy_end got=%b exp=0", busy); end
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL one_cmd_ready_end got=%b exp=1", cmd_ready); end
  endtask

  task automatic test_addr_only();
    int w0, d0;
    set_slots(1'b1, 1'b1, 8'h00);
    w0 = wr_cnt; d0 = done_cnt;
    send_cmd(7'h7F, 3'd0);
    run_txn(30);
    checks++; if (byte_at(0) !== 8'hFE) begin errors++; $display("FAIL addr_only_bits got=%h exp=fe", byte_at(0)); end
    checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL addr_only_done_count got=%0d exp=1", done_cnt - d0); end
    checks++; if (done_at !== 9) begin errors++; $display("FAIL addr_only_done_cycle got=%0d exp=9", done_at); end
    checks++; if (wr_cnt - w0 !== 0) begin errors++; $display("FAIL addr_only_wr_ready got=%0d exp=0", wr_cnt - w0); end
    checks++; if (nack !== 1'b1) begin errors++; $display("FAIL addr_only_nack got=%b exp=1", nack); end
    checks++; if (sda_oe !== 1'b0) begin errors++; $display("FAIL addr_only_sda_oe got=%b exp=0", sda_oe); end
  endtask

  task automatic test_underflow();
    int w0, d0;
    set_slots(1'b0, 1'b1, 8'h3C);
    wv[1] = 1'b0;
    w0 = wr_cnt; d0 = done_cnt;
    send_cmd(7'h2A, 3'd3);
    run_txn(50);
    checks++; if (byte_at(9) !== 8'h3C) begin errors++; $display("FAIL underflow_data_bits got=%h exp=3c", byte_at(9)); end
    checks++; if (wr_cnt - w0 !== 1) begin errors++; $display("FAIL underflow_wr_ready got=%0d exp=1", wr_cnt - w0); end
    checks++; if (done_at !== 18) begin errors++; $display("FAIL underflow_done_cycle got=%0d exp=18", done_at); end
    checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL underflow_done_count got=%0d exp=1", done_cnt - d0); end
    checks++; if (nack !== 1'b1) begin errors++; $display("FAIL underflow_nack got=%b exp=1", nack); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL underflow_busy got=%b exp=0", busy); end
  endtask

  task automatic test_nack_policy();
    int w0, d0, exp_done, exp_wr;
    set_slots(1'b0, 1'b1, 8'h81);
    ack_v[0] = 1'b1;
`ifdef I2C_NACK_ABORT_EN
    exp_done = 9;  exp_wr = 0;
`else
    exp_done = 27; exp_wr = 2;
`endif
    w0 = wr_cnt; d0 = done_cnt;
    send_cmd(7'h13, 3'd2);
    run_txn(50);
    checks++; if (wr_cnt - w0 !== exp_wr) begin errors++; $display("FAIL nack_wr_ready got=%0d exp=%0d", wr_cnt - w0, exp_wr); end
    checks++; if (done_at !== exp_done) begin errors++; $display("FAIL nack_done_cycle got=%0d exp=%0d", done_at, exp_done); end
    checks++; if (nack !== 1'b1) begin errors++; $display("FAIL nack_flag got=%b exp=1", nack); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL nack_busy got=%b exp=0", busy); end
  endtask

  task automatic test_len_saturate();
    int w0, d0;
    set_slots(1'b0, 1'b1, 8'hF0);
    w0 = wr_cnt; d0 = done_cnt;
    send_cmd(7'h01, 3'd7);
    run_txn(60);
    checks++; if (wr_cnt - w0 !== 4) begin errors++; $display("FAIL sat_wr_ready got=%0d exp=4", wr_cnt - w0); end
    checks++; if (done_at !== 45) begin errors++; $display("FAIL sat_done_cycle got=%0d exp=45", done_at); end
    checks++; if (byte_at(36) !== 8'hF3) begin errors++; $display("FAIL sat_last_byte got=%h exp=f3", byte_at(36)); end
    checks++; if (nack !== 1'b0) begin errors++; $display("FAIL sat_nack got=%b exp=0", nack); end
  endtask

  task automatic test_reset_mid();
    int d0;
    set_slots(1'b0, 1'b1, 8'hA5);
    d0 = done_cnt;
    send_cmd(7'h50, 3'd1);
    for (int i = 0; i < 13; i++) begin
      do_low(i);
      do_high(i);
    end
    do_low(13);
    checks++; if (sda_oe !== 1'b1) begin errors++; $display("FAIL mid_pre_sda_oe got=%b exp=1", sda_oe); end
    @(negedge mclk);
    rst = 1'b1;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_rst_busy got=%b exp=0", busy); end
    checks++; if (sda_oe !== 1'b0) begin errors++; $display("FAIL mid_rst_sda_oe got=%b exp=0", sda_oe); end
    checks++; if (sda_o !== 1'b1) begin errors++; $display("FAIL mid_rst_sda_o got=%b exp=1", sda_o); end
    checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL mid_rst_cmd_ready got=%b exp=0", cmd_ready); end
    scl_i = 1'b1;
    sda_i = 1'b1;
    wait_mclk(2);
    @(negedge mclk);
    rst = 1'b0;
    #1;
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL mid_release_cmd_ready got=%b exp=1", cmd_ready); end
    wait_mclk(1);
    checks++; if (done_cnt - d0 !== 0) begin errors++; $display("FAIL mid_no_done got=%0d exp=0", done_cnt - d0); end
    set_slots(1'b0, 1'b1, 8'h00);
    d0 = done_cnt;
    send_cmd(7'h11, 3'd0);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_new_busy got=%b exp=1", busy); end
    run_txn(30);
    checks++; if (byte_at(0) !== 8'h22) begin errors++; $display("FAIL mid_new_bits got=%h exp=22", byte_at(0)); end
    checks++; if (done_at !== 9) begin errors++; $display("FAIL mid_new_done_cycle got=%0d exp=9", done_at); end
    checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL mid_new_done_count got=%0d exp=1", done_cnt - d0); end
    checks++; if (nack !== 1'b0) begin errors++; $display("FAIL mid_new_nack got=%b exp=0", nack); end
  endtask

  initial begin
    test_reset();
    test_addr_only();
    test_one_byte();
    test_underflow();
    test_nack_policy();
    test_len_saturate();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
